alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Issue stage that drives the 64-bit ALU. Sits between register-read/decode and the ALU.
- Accepts decoded instruction fields and operands on a valid/ready handshake.
- Generates the 4-bit ALU control code from ALUOp/funct fields and selects operand b (rs2 or immediate).
- Presents a registered, back-pressurable operand/opcode bundle through a 2-entry skid buffer, and keeps issue/illegal counters.

Parameters:
- DATA_W, 64, operand width; must match the ALU.
- CNT_W, 16, width of the issue and illegal counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  stage can accept a bundle.
- alu_op_class  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  input  3  instruction funct3.
- funct7_5  input  1  instruction bit 30.
- alusrc  input  1  1 selects imm as operand b.
- rs1_data  input  DATA_W  operand a source.
- rs2_data  input  DATA_W  operand b source when alusrc=0.
- imm  input  DATA_W  sign-extended immediate.
- out_valid  output  1  ALU bundle valid.
- out_ready  input  1  ALU/execute stage accepts bundle.
- a  output  DATA_W  ALU operand a.
- b  output  DATA_W  ALU operand b.
- ALuop  output  4  ALU control code.
- illegal  output  1  bundle carries an undecodable operation.
- issue_cnt  output  CNT_W  bundles delivered (out_valid & out_ready).
- illegal_cnt  output  CNT_W  delivered bundles with illegal=1.

Behaviour:
- Reset (rst_n=0, async): both buffer entries empty; out_valid=0, in_ready=1; a, b=0; ALuop=4'b0000; illegal=0; counters=0.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100.
- Decode for class 00: ADD.
- Decode for class 01: SUB.
- Decode for class 10:
  - funct3 000 with funct7_5=0 -> ADD; with funct7_5=1 -> SUB.
  - 111 -> AND; 110 -> OR.
- Decode for class 11: funct3 000 -> ADD (funct7_5 ignored); 111 -> AND; 110 -> OR.
- Any other combination: ALuop=4'b1111, illegal=1. The bundle is still issued; the ALU returns 0 for it.
- Operand selection: b = alusrc ? imm : rs2_data; a = rs1_data. No arithmetic and no width change.
- Transfer: a bundle transfers on in_valid & in_ready. Latency 1 cycle: the bundle appears on the outputs the cycle after acceptance.
- Buffer organisation: main output register plus one skid entry.
- in_ready is registered and equals "skid entry empty". It never depends combinationally on out_ready.
- When the output register holds data and out_ready=0, a newly accepted bundle goes to the skid entry and in_ready drops next cycle.
- When the output drains (out_ready=1), the skid contents move to the output register and in_ready rises the following cycle.
- Simultaneous accept and drain with skid empty: the new bundle goes straight to the output register. out_valid stays 1; no bubble.
- Outputs hold stable while out_valid=1 & out_ready=0.
- Ordering: strict FIFO; no bundle is dropped or duplicated except by flush.
- flush=1:
  - Next edge empties both entries: out_valid=0, in_ready=1.
  - A bundle presented in the flush cycle is discarded.
  - A delivery in the flush cycle (out_valid & out_ready) still counts.
  - Data registers keep stale values; only the valid bits clear.
- Counters: issue_cnt increments on each delivery; illegal_cnt increments additionally when illegal=1. Both wrap modulo 2^CNT_W and are unaffected by flush.
- Reset mid-operation: immediate return to the reset state; buffered bundles are lost.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_ILLEGAL);
  - the op-class constants (OPC_LDST, OPC_BR, OPC_R, OPC_I);
  - the packed bundle typedef alu_bundle_t {a, b, ALuop, illegal}.
- One natural sub-module: alu_ctrl_decode (combinational, op class/funct -> ALuop, illegal). Instantiated once ahead of the skid buffer.

Test Plan:
- R-type add: class=10, funct3=000, funct7_5=0, rs1=5, rs2=7, alusrc=0, out_ready=1 -> next cycle out_valid=1, a=5, b=7, ALuop=0010, illegal=0; issue_cnt=1 after delivery.
- I-type and branch: class=11, funct3=111, imm=0xFF, alusrc=1 -> ALuop=0000, b=0xFF. Then class=01 -> ALuop=0110. R-type funct3=000, funct7_5=1 -> 0110.
- Illegal: class=10, funct3=001 -> ALuop=1111, illegal=1, delivered; illegal_cnt=1, issue_cnt=1.
- Back-pressure: out_ready=0, stream 3 bundles (rs1=1,2,3) with in_valid held high -> bundles 1 and 2 accepted, in_ready=0 from the cycle after bundle 2 is accepted, outputs hold a=1. Release out_ready -> delivered in order 1,2,3 with no loss.
- Flush: two bundles buffered (in_ready=0) plus in_valid=1, assert flush one cycle -> next cycle out_valid=0, in_ready=1, counters unchanged, no bundle ever delivered.
- Async reset mid-stream: drop rst_n between clock edges with buffer full -> out_valid=0, in_ready=1, counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: control codes, op classes and the
// registered operand/opcode bundle handed to the ALU.
package alu_pkg;

  localparam int ALU_DATA_W = 64;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] OPC_LDST = 2'b00;
  localparam logic [1:0] OPC_BR   = 2'b01;
  localparam logic [1:0] OPC_R    = 2'b10;
  localparam logic [1:0] OPC_I    = 2'b11;

  // Operand fields are sized to the ALU datapath; the issue stage DATA_W must match.
  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [3:0]            ALuop;
    logic                  illegal;
  } alu_bundle_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: op class plus funct fields to 4-bit ALU code.
// Undecodable combinations produce ALU_ILLEGAL with the illegal flag set.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] aluop,
  output logic       illegal
);

  always_comb begin
    aluop   = ALU_ILLEGAL;
    illegal = 1'b1;
    case (alu_op_class)
      OPC_LDST: begin
        aluop   = ALU_ADD;
        illegal = 1'b0;
      end
      OPC_BR: begin
        aluop   = ALU_SUB;
        illegal = 1'b0;
      end
      OPC_R: begin
        case (funct3)
          3'b000: begin
            aluop   = funct7_5 ? ALU_SUB : ALU_ADD;
            illegal = 1'b0;
          end
          3'b111: begin
            aluop   = ALU_AND;
            illegal = 1'b0;
          end
          3'b110: begin
            aluop   = ALU_OR;
            illegal = 1'b0;
          end
          default: ;
        endcase
      end
      OPC_I: begin
        // funct7_5 is part of the immediate here, so it must not steer ADD/SUB.
        case (funct3)
          3'b000: begin
            aluop   = ALU_ADD;
            illegal = 1'b0;
          end
          3'b111: begin
            aluop   = ALU_AND;
            illegal = 1'b0;
          end
          3'b110: begin
            aluop   = ALU_OR;
            illegal = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the ALU control code, selects operand b and presents
// the bundle through an output register plus one skid entry, with delivery counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op_class,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              alusrc,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [3:0]        ALuop,
  output logic              illegal,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  logic        dec_illegal;
  logic [3:0]  dec_aluop;
  alu_bundle_t in_bundle;
  alu_bundle_t out_q;
  alu_bundle_t skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;
  logic        accept;
  logic        deliver;
  logic        out_free;

  alu_ctrl_decode u_decode (
    .alu_op_class (alu_op_class),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .aluop        (dec_aluop),
    .illegal      (dec_illegal)
  );

  always_comb begin
    in_bundle         = '0;
    in_bundle.a       = rs1_data;
    in_bundle.b       = alusrc ? imm : rs2_data;
    in_bundle.ALuop   = dec_aluop;
    in_bundle.illegal = dec_illegal;
  end

  // in_ready comes straight from a flop, so it never sees out_ready combinationally.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid_q & out_ready;
  assign out_free = ~out_valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      // accept implies the skid is empty, so at most one source feeds the output.
      out_valid_q  <= skid_valid_q | accept;
      skid_valid_q <= 1'b0;
    end else if (accept) begin
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (out_free) begin
        if (skid_valid_q) begin
          out_q <= skid_q;
        end else if (accept) begin
          out_q <= in_bundle;
        end
      end else if (accept) begin
        skid_q <= in_bundle;
      end
    end
  end

  // Deliveries count even in a flush cycle; the ALU has already taken the bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt   <= '0;
      illegal_cnt <= '0;
    end else if (deliver) begin
      issue_cnt <= issue_cnt + 1'b1;
      if (out_q.illegal) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign a         = out_q.a;
  assign b         = out_q.b;
  assign ALuop     = out_q.ALuop;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode, operand select,
// skid-buffer back-pressure, flush and asynchronous reset.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op_class;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic              alusrc;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] imm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [3:0]        ALuop;
  logic              illegal;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  illegal_cnt;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_issue = '0;
  logic [CNT_W-1:0] exp_illc  = '0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op_class (alu_op_class),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .alusrc       (alusrc),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .a            (a),
    .b            (b),
    .ALuop        (ALuop),
    .illegal      (illegal),
    .issue_cnt    (issue_cnt),
    .illegal_cnt  (illegal_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                       input logic src, input logic [63:0] r1, input logic [63:0] r2,
                       input logic [63:0] im);
    alu_op_class = cls;
    funct3       = f3;
    funct7_5     = f7;
    alusrc       = src;
    rs1_data     = r1;
    rs2_data     = r2;
    imm          = im;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (a !== 64'd0 || b !== 64'd0) begin n_fail++; $display("FAIL reset_ab got %h/%h want 0/0", a, b); end
    n_checks++; if (ALuop !== 4'b0000 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_op got %b/%b want 0000/0", ALuop, illegal); end
    n_checks++; if (issue_cnt !== 16'd0 || illegal_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", issue_cnt, illegal_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rtype_add();
    out_ready = 1'b1;
    drive(2'b10, 3'b000, 1'b0, 1'b0, 64'd5, 64'd7, 64'd99);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", out_valid); end
    n_checks++; if (a !== 64'd5 || b !== 64'd7) begin n_fail++; $display("FAIL add_ab got %0d/%0d want 5/7", a, b); end
    n_checks++; if (ALuop !== 4'b0010 || illegal !== 1'b0) begin n_fail++; $display("FAIL add_op got %b/%b want 0010/0", ALuop, illegal); end
    n_checks++; if (issue_cnt !== 16'd0) begin n_fail++; $display("FAIL add_cnt_before got %0d want 0", issue_cnt); end
    tick();
    exp_issue = exp_issue + 1'b1;
    n_checks++; if (issue_cnt !== 16'd1) begin n_fail++; $display("FAIL add_cnt_after got %0d want 1", issue_cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drained got %b want 0", out_valid); end
  endtask

  typedef struct packed {
    logic [1:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic        src;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] im;
    logic [3:0]  op;
    logic        ill;
  } vec_t;

  task automatic test_decode();
    vec_t v[11];
    logic [63:0] exp_b;
    v[0]  = '{2'b11, 3'b111, 1'b0, 1'b1, 64'd3,  64'd9,  64'hFF, 4'b0000, 1'b0};
    v[1]  = '{2'b01, 3'b000, 1'b0, 1'b0, 64'd10, 64'd4,  64'd1,  4'b0110, 1'b0};
    v[2]  = '{2'b10, 3'b000, 1'b1, 1'b0, 64'd8,  64'd2,  64'd1,  4'b0110, 1'b0};
    v[3]  = '{2'b10, 3'b111, 1'b0, 1'b0, 64'd11, 64'd12, 64'd1,  4'b0000, 1'b0};
    v[4]  = '{2'b10, 3'b110, 1'b0, 1'b0, 64'd13, 64'd14, 64'd1,  4'b0001, 1'b0};
    v[5]  = '{2'b11, 3'b000, 1'b1, 1'b1, 64'd15, 64'd16, 64'd77, 4'b0010, 1'b0};
    v[6]  = '{2'b11, 3'b110, 1'b0, 1'b1, 64'd17, 64'd18, 64'h5A, 4'b0001, 1'b0};
    v[7]  = '{2'b00, 3'b010, 1'b1, 1'b1, 64'd19, 64'd20, 64'd40, 4'b0010, 1'b0};
    v[8]  = '{2'b10, 3'b001, 1'b0, 1'b0, 64'd21, 64'd22, 64'd1,  4'b1111, 1'b1};
    v[9]  = '{2'b11, 3'b001, 1'b0, 1'b1, 64'd23, 64'd24, 64'd3,  4'b1111, 1'b1};
    v[10] = '{2'b10, 3'b101, 1'b1, 1'b0, 64'd25, 64'd26, 64'd1,  4'b1111, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(v[i].cls, v[i].f3, v[i].f7, v[i].src, v[i].r1, v[i].r2, v[i].im);
      exp_b = v[i].src ? v[i].im : v[i].r2;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || a !== v[i].r1 || b !== exp_b) begin n_fail++; $display("FAIL decode_data[%0d] got v=%b a=%h b=%h want v=1 a=%h b=%h", i, out_valid, a, b, v[i].r1, exp_b); end
      n_checks++; if (ALuop !== v[i].op || illegal !== v[i].ill) begin n_fail++; $display("FAIL decode_op[%0d] got %b/%b want %b/%b", i, ALuop, illegal, v[i].op, v[i].ill); end
      tick();
      exp_issue = exp_issue + 1'b1;
      if (v[i].ill) exp_illc = exp_illc + 1'b1;
      n_checks++; if (issue_cnt !== exp_issue || illegal_cnt !== exp_illc) begin n_fail++; $display("FAIL decode_cnt[%0d] got %0d/%0d want %0d/%0d", i, issue_cnt, illegal_cnt, exp_issue, exp_illc); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 3'b000, 1'b0, 1'b0, 64'd20 + 64'(i), 64'd1, 64'd0);
      tick();
      n_checks++; if (out_valid !== 1'b1 || a !== 64'd20 + 64'(i) || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] got v=%b a=%0d rdy=%b want v=1 a=%0d rdy=1", i, out_valid, a, in_ready, 20 + i); end
    end
    in_valid = 1'b0;
    tick();
    exp_issue = exp_issue + 16'd4;
    n_checks++; if (issue_cnt !== exp_issue || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_cnt got %0d v=%b want %0d v=0", issue_cnt, out_valid, exp_issue); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(2'b10, 3'b000, 1'b0, 1'b0, 64'd1, 64'd0, 64'd0);
    tick();
    n_checks++; if (out_valid !== 1'b1 || a !== 64'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first got v=%b a=%0d rdy=%b want 1/1/1", out_valid, a, in_ready); end
    rs1_data = 64'd2;
    tick();
    n_checks++; if (in_ready !== 1'b0 || a !== 64'd1) begin n_fail++; $display("FAIL bp_skid got rdy=%b a=%0d want 0/1", in_ready, a); end
    rs1_data = 64'd3;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0 || a !== 64'd1 || out_valid !== 1'b1 || issue_cnt !== exp_issue) begin n_fail++; $display("FAIL bp_hold got rdy=%b a=%0d v=%b cnt=%0d want 0/1/1/%0d", in_ready, a, out_valid, issue_cnt, exp_issue); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (a !== 64'd2 || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second got a=%0d v=%b rdy=%b want 2/1/1", a, out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (a !== 64'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_third got a=%0d v=%b want 3/1", a, out_valid); end
    tick();
    exp_issue = exp_issue + 16'd3;
    n_checks++; if (out_valid !== 1'b0 || issue_cnt !== exp_issue) begin n_fail++; $display("FAIL bp_done got v=%b cnt=%0d want 0/%0d", out_valid, issue_cnt, exp_issue); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(2'b10, 3'b001, 1'b0, 1'b0, 64'd40, 64'd0, 64'd0);
    tick();
    rs1_data = 64'd41;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full got rdy=%b want 0", in_ready); end
    rs1_data = 64'd42;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    n_checks++; if (issue_cnt !== exp_issue || illegal_cnt !== exp_illc) begin n_fail++; $display("FAIL flush_cnt got %0d/%0d want %0d/%0d", issue_cnt, illegal_cnt, exp_issue, exp_illc); end
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0 || issue_cnt !== exp_issue) begin n_fail++; $display("FAIL flush_nodeliver got v=%b cnt=%0d want 0/%0d", out_valid, issue_cnt, exp_issue); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rs1_data  = 64'd50;
    tick();
    rs1_data  = 64'd51;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_issue = exp_issue + 1'b1;
    exp_illc  = exp_illc + 1'b1;
    n_checks++; if (out_valid !== 1'b0 || issue_cnt !== exp_issue || illegal_cnt !== exp_illc) begin n_fail++; $display("FAIL flush_deliver got v=%b cnt=%0d/%0d want 0/%0d/%0d", out_valid, issue_cnt, illegal_cnt, exp_issue, exp_illc); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || issue_cnt !== exp_issue) begin n_fail++; $display("FAIL flush_discard got v=%b cnt=%0d want 0/%0d", out_valid, issue_cnt, exp_issue); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(2'b10, 3'b000, 1'b0, 1'b0, 64'd60, 64'd0, 64'd0);
    tick();
    rs1_data = 64'd61;
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_full got rdy=%b v=%b want 0/1", in_ready, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_now got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    n_checks++; if (issue_cnt !== 16'd0 || illegal_cnt !== 16'd0 || a !== 64'd0) begin n_fail++; $display("FAIL arst_clear got cnt=%0d/%0d a=%0d want 0/0/0", issue_cnt, illegal_cnt, a); end
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0 || issue_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_after got v=%b cnt=%0d want 0/0", out_valid, issue_cnt); end
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
